// File: rtl/scmp_dad_seq.sv
// rtl/scmp_dad_seq.sv - SC/MP DAD/DAE decimal-add sequencer that borrows the shared ALU
// Macro SCMP_DAD_FIXED_LATENCY_EN: always visit both +6 fix states (latency 5); otherwise skip unneeded fixes.
package scmp_alu_pkg;
  typedef enum logic [3:0] {
    ALU_OP_NUL           = 4'h0,
    ALU_OP_ADD           = 4'h1,
    ALU_OP_ADD_NOCARRYIN = 4'h2,
    ALU_OP_AND           = 4'h3,
    ALU_OP_OR            = 4'h4,
    ALU_OP_XOR           = 4'h5,
    ALU_OP_DA            = 4'h6
  } ALU_OP_t;
endpackage

module scmp_dad_seq
  import scmp_alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] dad_a,
  input  logic [7:0] dad_b,
  input  logic       dad_cy,
  output logic       busy,
  output logic       done,
  output logic [7:0] dad_res,
  output logic       dad_cy_o,
  input  ALU_OP_t    uc_op,
  input  logic [7:0] uc_a,
  input  logic [7:0] uc_b,
  input  logic       uc_cy,
  output ALU_OP_t    alu_op,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic       alu_cy,
  input  logic [7:0] alu_res,
  input  logic       alu_cy_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_LO_ADD, S_LO_FIX, S_HI_ADD, S_HI_FIX, S_DONE
  } state_t;

  state_t     state_q;
  logic [7:0] a_q, b_q;
  logic       cy_q;
  logic [4:0] lo_raw_q, hi_raw_q;
  logic       c_lo_q, c_hi_q;
  logic [3:0] lo_q;
  logic       busy_q, done_q;
  logic [7:0] res_q;
  logic       res_cy_q;

  // Decimal carry comes from the compare, never from ALU bit 4.
  logic [4:0] sum_raw;
  logic       sum_gt9;
  assign sum_raw = alu_res[4:0];
  assign sum_gt9 = (sum_raw > 5'd9);

  logic unused_alu_bits;
  assign unused_alu_bits = &{1'b0, alu_cy_o, alu_res[7:5]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      cy_q     <= 1'b0;
      lo_raw_q <= 5'h00;
      hi_raw_q <= 5'h00;
      c_lo_q   <= 1'b0;
      c_hi_q   <= 1'b0;
      lo_q     <= 4'h0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      res_q    <= 8'h00;
      res_cy_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q     <= dad_a;
            b_q     <= dad_b;
            cy_q    <= dad_cy;
            busy_q  <= 1'b1;
            state_q <= S_LO_ADD;
          end
        end
        S_LO_ADD: begin
          lo_raw_q <= sum_raw;
          c_lo_q   <= sum_gt9;
          lo_q     <= sum_raw[3:0];
`ifdef SCMP_DAD_FIXED_LATENCY_EN
          state_q  <= S_LO_FIX;
`else
          state_q  <= sum_gt9 ? S_LO_FIX : S_HI_ADD;
`endif
        end
        S_LO_FIX: begin
          lo_q    <= alu_res[3:0];
          state_q <= S_HI_ADD;
        end
        S_HI_ADD: begin
          hi_raw_q <= sum_raw;
          c_hi_q   <= sum_gt9;
`ifdef SCMP_DAD_FIXED_LATENCY_EN
          state_q  <= S_HI_FIX;
`else
          if (sum_gt9) begin
            state_q <= S_HI_FIX;
          end else begin
            res_q    <= {sum_raw[3:0], lo_q};
            res_cy_q <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end
`endif
        end
        S_HI_FIX: begin
          res_q    <= {alu_res[3:0], lo_q};
          res_cy_q <= c_hi_q;
          done_q   <= 1'b1;
          state_q  <= S_DONE;
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // NUL passes B through, so an uncorrected digit still comes back via alu_res.
  always_comb begin
    alu_op = uc_op;
    alu_a  = uc_a;
    alu_b  = uc_b;
    alu_cy = uc_cy;
    case (state_q)
      S_IDLE: ;
      S_LO_ADD: begin
        alu_op = ALU_OP_ADD;
        alu_a  = {4'h0, a_q[3:0]};
        alu_b  = {4'h0, b_q[3:0]};
        alu_cy = cy_q;
      end
      S_LO_FIX: begin
        alu_op = c_lo_q ? ALU_OP_ADD_NOCARRYIN : ALU_OP_NUL;
        alu_a  = c_lo_q ? {3'b000, lo_raw_q} : 8'h00;
        alu_b  = c_lo_q ? 8'h06 : {3'b000, lo_raw_q};
        alu_cy = 1'b0;
      end
      S_HI_ADD: begin
        alu_op = ALU_OP_ADD;
        alu_a  = {4'h0, a_q[7:4]};
        alu_b  = {4'h0, b_q[7:4]};
        alu_cy = c_lo_q;
      end
      S_HI_FIX: begin
        alu_op = c_hi_q ? ALU_OP_ADD_NOCARRYIN : ALU_OP_NUL;
        alu_a  = c_hi_q ? {3'b000, hi_raw_q} : 8'h00;
        alu_b  = c_hi_q ? 8'h06 : {3'b000, hi_raw_q};
        alu_cy = 1'b0;
      end
      default: begin
        alu_op = ALU_OP_NUL;
        alu_a  = 8'h00;
        alu_b  = 8'h00;
        alu_cy = 1'b0;
      end
    endcase
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign dad_res  = res_q;
  assign dad_cy_o = res_cy_q;

endmodule

// File: tb/tb_scmp_dad_seq.sv
// tb/tb_scmp_dad_seq.sv - scoreboard bench for scmp_dad_seq with a behavioural SC/MP ALU
// Honours SCMP_DAD_FIXED_LATENCY_EN for the expected latency.
module tb_scmp_dad_seq;
  import scmp_alu_pkg::*;

`ifdef SCMP_DAD_FIXED_LATENCY_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] dad_a = 8'h00, dad_b = 8'h00;
  logic       dad_cy = 1'b0;
  logic       busy, done, dad_cy_o;
  logic [7:0] dad_res;
  ALU_OP_t    uc_op = ALU_OP_NUL;
  logic [7:0] uc_a = 8'h00, uc_b = 8'h00;
  logic       uc_cy = 1'b0;
  ALU_OP_t    alu_op;
  logic [7:0] alu_a, alu_b, alu_res;
  logic       alu_cy, alu_cy_o;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] res;
    logic       cy;
    int         lat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  scmp_dad_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dad_a(dad_a), .dad_b(dad_b), .dad_cy(dad_cy),
    .busy(busy), .done(done), .dad_res(dad_res), .dad_cy_o(dad_cy_o),
    .uc_op(uc_op), .uc_a(uc_a), .uc_b(uc_b), .uc_cy(uc_cy),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_cy(alu_cy),
    .alu_res(alu_res), .alu_cy_o(alu_cy_o)
  );

  logic [8:0] alu_sum;
  always_comb begin
    alu_sum = 9'h000;
    case (alu_op)
      ALU_OP_ADD:           alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_cy};
      ALU_OP_ADD_NOCARRYIN: alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
      ALU_OP_AND:           alu_sum = {1'b0, alu_a & alu_b};
      ALU_OP_OR:            alu_sum = {1'b0, alu_a | alu_b};
      ALU_OP_XOR:           alu_sum = {1'b0, alu_a ^ alu_b};
      ALU_OP_NUL:           alu_sum = {1'b0, alu_b};
      default:              alu_sum = 9'h000;
    endcase
  end
  assign alu_res  = alu_sum[7:0];
  assign alu_cy_o = alu_sum[8];

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic c);
    exp_t e;
    int s_lo, s_hi;
    bit cl, ch;
    s_lo = int'(a[3:0]) + int'(b[3:0]) + int'(c);
    cl = (s_lo > 9);
    if (cl) s_lo = s_lo + 6;
    s_hi = int'(a[7:4]) + int'(b[7:4]) + int'(cl);
    ch = (s_hi > 9);
    if (ch) s_hi = s_hi + 6;
    e.res = {4'(s_hi % 16), 4'(s_lo % 16)};
    e.cy  = ch;
    e.lat = FIXED ? 5 : 3 + int'(cl) + int'(ch);
    return e;
  endfunction

  // Pulses start for one edge, then checks cycle-1 ALU drive with uc_* scrambled.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic c);
    @(posedge clk); #1;
    dad_a = a; dad_b = b; dad_cy = c; start = 1'b1;
    sb.push_back(model(a, b, c));
    @(posedge clk); #1;
    start = 1'b0;
    uc_op = ALU_OP_AND; uc_a = 8'hF0; uc_b = 8'h3C; uc_cy = 1'b1;
    #1;
    n_cmp++;
    if (alu_op !== ALU_OP_ADD || alu_a !== {4'h0, a[3:0]} || alu_b !== {4'h0, b[3:0]} || alu_cy !== c || busy !== 1'b1) begin
      n_err++;
      $display("FAIL lo_add_drive: op=%0d a=%h b=%h cy=%b busy=%b, want op=%0d a=%h b=%h cy=%b busy=1",
               alu_op, alu_a, alu_b, alu_cy, busy, ALU_OP_ADD, {4'h0, a[3:0]}, {4'h0, b[3:0]}, c);
    end
  endtask

  task automatic collect(input string tag, input int first_cyc);
    exp_t e;
    int cyc;
    bit seen;
    seen = 1'b0;
    cyc = 0;
    for (int i = first_cyc; i <= 12; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        cyc = i;
        seen = 1'b1;
        break;
      end
    end
    if (sb.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL %s scoreboard_empty: got done, want queued entry", tag);
      return;
    end
    e = sb.pop_front();
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL %s timeout: no done, want done in cycle %0d", tag, e.lat);
      return;
    end
    if (cyc != e.lat) begin
      n_err++;
      $display("FAIL %s latency: got %0d, want %0d", tag, cyc, e.lat);
    end
    n_cmp++;
    if (dad_res !== e.res || dad_cy_o !== e.cy) begin
      n_err++;
      $display("FAIL %s result: got %h cy %b, want %h cy %b", tag, dad_res, dad_cy_o, e.res, e.cy);
    end
  endtask

  task automatic watch_no_done(input string tag, input int n);
    int cnt;
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done === 1'b1) cnt++;
    end
    n_cmp++;
    if (cnt != 0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s extra_done: got %0d pulses busy=%b, want 0 pulses busy=0", tag, cnt, busy);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    uc_op = ALU_OP_XOR; uc_a = 8'h5A; uc_b = 8'hC3; uc_cy = 1'b1;
    #12;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || dad_res !== 8'h00 || dad_cy_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: busy=%b done=%b res=%h cy=%b, want 0 0 00 0", busy, done, dad_res, dad_cy_o);
    end
    n_cmp++;
    if (alu_op !== ALU_OP_XOR || alu_a !== 8'h5A || alu_b !== 8'hC3 || alu_cy !== 1'b1) begin
      n_err++;
      $display("FAIL reset_passthru: op=%0d a=%h b=%h cy=%b, want %0d 5a c3 1", alu_op, alu_a, alu_b, alu_cy, ALU_OP_XOR);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_passthrough;
    @(negedge clk);
    uc_op = ALU_OP_AND; uc_a = 8'hF0; uc_b = 8'h3C; uc_cy = 1'b0;
    #1;
    n_cmp++;
    if (alu_op !== ALU_OP_AND || alu_a !== 8'hF0 || alu_b !== 8'h3C || alu_cy !== 1'b0 || alu_res !== 8'h30) begin
      n_err++;
      $display("FAIL idle_passthru: op=%0d a=%h b=%h cy=%b res=%h, want %0d f0 3c 0 30",
               alu_op, alu_a, alu_b, alu_cy, alu_res, ALU_OP_AND);
    end
  endtask

  task automatic test_lo_fix;
    issue(8'h45, 8'h38, 1'b0);
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (alu_op !== ALU_OP_ADD_NOCARRYIN || alu_a !== 8'h0D || alu_b !== 8'h06 || alu_cy !== 1'b0) begin
      n_err++;
      $display("FAIL lo_fix_drive: op=%0d a=%h b=%h cy=%b, want %0d 0d 06 0",
               alu_op, alu_a, alu_b, alu_cy, ALU_OP_ADD_NOCARRYIN);
    end
    collect("45+38", 3);
  endtask

  task automatic test_vectors;
    logic [7:0] va[6];
    logic [7:0] vb[6];
    logic       vc[6];
    va = '{8'h99, 8'h99, 8'hFF, 8'h12, 8'h00, 8'h50};
    vb = '{8'h99, 8'h01, 8'hFF, 8'h34, 8'h00, 8'h49};
    vc = '{1'b1,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1};
    for (int i = 0; i < 6; i++) begin
      issue(va[i], vb[i], vc[i]);
      collect($sformatf("vec%0d", i), 1);
    end
    for (int i = 0; i < 6; i++) begin
      logic [7:0] ra, rb;
      ra = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      rb = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      issue(ra, rb, 1'($urandom_range(0, 1)));
      collect($sformatf("rnd%0d", i), 1);
    end
  endtask

  task automatic test_start_ignored;
    issue(8'h45, 8'h38, 1'b0);
    @(negedge clk);
    @(negedge clk);
    dad_a = 8'h11; dad_b = 8'h22; dad_cy = 1'b1; start = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    start = 1'b0;
    collect("start_ign", 4);
    watch_no_done("start_ign", 8);
  endtask

  task automatic test_reset_midop;
    issue(8'h45, 8'h38, 1'b0);
    void'(sb.pop_front());
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || dad_res !== 8'h00 || dad_cy_o !== 1'b0) begin
      n_err++;
      $display("FAIL midop_reset: busy=%b done=%b res=%h cy=%b, want 0 0 00 0", busy, done, dad_res, dad_cy_o);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    watch_no_done("midop_reset", 8);
  endtask

  task automatic test_back_to_back;
    exp_t e;
    issue(8'h27, 8'h16, 1'b0);
    collect("b2b_first", 1);
    dad_a = 8'h58; dad_b = 8'h67; dad_cy = 1'b1; start = 1'b1;
    e = model(8'h58, 8'h67, 1'b1);
    sb.push_back(e);
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_done_start: busy=%b, want 0 (start in DONE ignored)", busy);
    end
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_accept: busy=%b, want 1", busy);
    end
    collect("b2b_second", 1);
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_lo_fix();
    test_vectors();
    test_start_ignored();
    test_reset_midop();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/scmp_dad_seq.md
# scmp_dad_seq

Multi-cycle decimal-add sequencer that owns the shared SC/MP ALU while running DAD/DAE. When idle, it passes microcode ALU requests straight through to the ALU. On `start`, it takes the ALU over and issues a nibble-wise binary add followed by a +6 correction for each digit, then returns a packed-BCD result and decimal carry. It sits between the microcode sequencer and the ALU, replacing the unimplemented `ALU_OP_DA` path.

## Interface
- No parameters.
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: begin decimal add; honoured only in IDLE.
- `dad_a` in 8: packed-BCD operand A (accumulator); latched on accepted `start`.
- `dad_b` in 8: packed-BCD operand B (memory data); latched on accepted `start`.
- `dad_cy` in 1: carry-in (CY/L flag); latched on accepted `start`.
- `busy` out 1: sequencer owns the ALU.
- `done` out 1: single-cycle completion pulse.
- `dad_res` out 8: packed-BCD result; held until the next accepted `start`.
- `dad_cy_o` out 1: decimal carry-out; held with `dad_res`.
- `uc_op` in ALU_OP_t: microcode ALU op request.
- `uc_a`, `uc_b` in 8 each: microcode ALU operands.
- `uc_cy` in 1: microcode ALU carry-in.
- `alu_op` out ALU_OP_t: op to ALU.
- `alu_a`, `alu_b` out 8 each: operands to ALU.
- `alu_cy` out 1: carry-in to ALU.
- `alu_res` in 8: ALU result.
- `alu_cy_o` in 1: ALU carry-out; unused by the sequencer.

## Operation
- States: IDLE, LO_ADD, LO_FIX, HI_ADD, HI_FIX, DONE.
- IDLE: `alu_*` = `uc_*` combinationally. `start=1` latches operands and carry, then goes to LO_ADD.
- LO_ADD: drive `ALU_OP_ADD`, A=`{4'h0,a[3:0]}`, B=`{4'h0,b[3:0]}`, cy=latched carry.
  - Capture `lo_raw = alu_res[4:0]` (range 0..31).
  - Set `c_lo = (lo_raw > 9)`.
- LO_FIX: if `c_lo`, drive `ALU_OP_ADD_NOCARRYIN` with A=`{3'b0,lo_raw}`, B=8'h06, cy=0. Otherwise drive `ALU_OP_NUL` with B=`{3'b0,lo_raw}`. Capture `lo = alu_res[3:0]`.
- HI_ADD: same as LO_ADD using the `[7:4]` nibbles, with cy=`c_lo`. Capture `hi_raw` and `c_hi = (hi_raw > 9)`.
- HI_FIX: same as LO_FIX on `hi_raw`. Capture `hi`.
- DONE: `dad_res = {hi,lo}`, `dad_cy_o = c_hi`, `done=1`. Next state is IDLE.
- Decimal carry is the compare result (`> 9`), never ALU bit 4. This keeps non-BCD digits deterministic: digit sum s maps to `(s+6)[3:0]` with carry 1 when s>9, else s with carry 0.
- While not IDLE, `uc_*` are ignored, and `start` is ignored.
- ALU Ov is not touched by this block; the ALU overflow input remains microcode-driven.

## Timing
- Reset values:
  - state IDLE
  - `busy=0`, `done=0`
  - `dad_res=8'h00`, `dad_cy_o=0`
  - all internal latches 0
  - `alu_*` = `uc_*` (pass-through)
- `busy=1` in LO_ADD through DONE inclusive; 0 in IDLE.
- Fixed latency: `start` accepted at edge 0, `done` high in cycle 5 (states L_ADD, L_FIX, H_ADD, H_FIX occupy cycles 1–4). `dad_res` and `dad_cy_o` become valid in the same cycle as `done`.
- Back-to-back: `start` may be asserted in the DONE cycle but is ignored. The earliest accepted `start` is in the first IDLE cycle, giving 6 cycles between starts.
- Reset asserted mid-operation: immediate return to IDLE, no `done` pulse, result cleared to 0.
- ALU path is purely combinational: each ALU state issues and captures within one cycle.

## Configuration
- `SCMP_DAD_FIXED_LATENCY_EN` defined: behaviour exactly as above. Fix states are always visited, using `ALU_OP_NUL` when no correction is needed, so latency is always 5.
- Undefined: LO_FIX is skipped when `c_lo=0` (lo = `lo_raw[3:0]` captured in LO_ADD). HI_FIX is likewise skipped when `c_hi=0`. Latency is 3, 4 or 5 cycles; `done` semantics are unchanged.

## Test plan
- a=0x45, b=0x38, cy=0 -> `dad_res`=0x83, `dad_cy_o`=0, `done` in cycle 5; LO_FIX shows `alu_op`=ADD_NOCARRYIN with B=0x06.
- a=0x99, b=0x99, cy=1 -> 0x99, carry 1. Also a=0x99, b=0x01, cy=0 -> 0x00, carry 1.
- Non-BCD input a=0xFF, b=0xFF, cy=1 -> 0x55, carry 1.
- IDLE with `uc_op`=ALU_OP_AND, `uc_a`=0xF0, `uc_b`=0x3C -> same values on `alu_*` in the same cycle. While busy, `uc_*` changes do not reach `alu_*`.
- `start` pulsed again during HI_ADD -> ignored, single `done`. `rst_n` low during HI_ADD -> `busy`=0 immediately, no `done`, `dad_res`=0x00.
- Without macro: a=0x12, b=0x34, cy=0 -> 0x46, carry 0, `done` in cycle 3. Same input with macro defined -> `done` in cycle 5.
